spi_flash_arbiter: RTL and testbench

Shares the single configuration-flash SPI port (the serial flash loader's dclk/sce/sdo/data0 pins) between two masters: requester 0, the JTAG-to-SPI bridge, and requester 1, a fabric user master such as a bitstream updater or parameter store. A four-state FSM on the system clock grants the port to one requester at a time using round-robin. It never truncates a transfer in progress and enforces a minimum chip-select-high gap between owners. The SPI signals themselves are muxed combinationally, so each master keeps its own SPI clock, for example tck.

---
 rtl/spi_arb_pkg.sv | 24 ++
 rtl/spi_arb_sync.sv | 28 ++
 rtl/spi_flash_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_spi_flash_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and constants for the configuration-flash SPI arbiter.
package spi_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } arb_state_t;

  // Requester indices: 0 is the JTAG-to-SPI bridge, 1 is the fabric user master
  localparam int REQ_JTAG = 0;
  localparam int REQ_USER = 1;

  // Width of the gap counter and the optional grant watchdog
  localparam int CNT_W = 16;

  // Map a requester index to its grant state
  function automatic arb_state_t grant_state(input logic idx);
    return idx ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/spi_arb_sync.sv
// spi_arb_sync: WIDTH-bit, SYNC_STAGES-deep flop synchronizer with a
// configurable asynchronous reset value.
module spi_arb_sync #(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [SYNC_STAGES];

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_pipe[i] <= RST_VAL;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: round-robin arbiter sharing the configuration-flash SPI
// port between the JTAG bridge (requester 0) and a fabric master (requester 1).
// Optional grant watchdog: define SPI_ARB_TIMEOUT_EN to build it.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no owner, SPI pins parked, arbitrate synchronized requests
// GRANT0 | requester 0 owns the port, its m_* pins drive spi_*
// GRANT1 | requester 1 owns the port, its m_* pins drive spi_*
// GAP    | chip select held high for CS_GAP cycles before next arbitration
module spi_flash_arbiter
  import spi_arb_pkg::*;
#(
  parameter int CS_GAP      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       timeout_evt,
  input  logic [1:0] m_csn,
  input  logic [1:0] m_clk,
  input  logic [1:0] m_si,
  output logic       m_so,
  output logic       spi_csn,
  output logic       spi_clk,
  output logic       spi_si,
  input  logic       spi_so
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [1:0]       w_req_s;
  logic [1:0]       w_csn_s;
  logic             r_last;
  logic [CNT_W-1:0] r_gap;
  logic [1:0]       r_gnt;
  logic [1:0]       w_gnt_nxt;
  logic             r_busy;
  logic             w_grant_entry;
  logic             w_to;
  logic             w_spi_csn;
  logic             w_spi_clk;
  logic             w_spi_si;

  spi_arb_sync #(
    .WIDTH      (2),
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (2'b00)
  ) u_sync_req (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (req),
    .o_q  (w_req_s)
  );

  // Chip selects reset high so a pending release is never seen as "in transfer"
  spi_arb_sync #(
    .WIDTH      (2),
    .SYNC_STAGES(SYNC_STAGES),
    .RST_VAL    (2'b11)
  ) u_sync_csn (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (m_csn),
    .o_q  (w_csn_s)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_wdog;
  logic             r_to_evt;
  logic             w_other_req;

  // The watchdog only runs while the non-owner is waiting
  always_comb begin
    w_other_req = 1'b0;
    case (r_state)
      GRANT0:  w_other_req = w_req_s[REQ_USER];
      GRANT1:  w_other_req = w_req_s[REQ_JTAG];
      default: w_other_req = 1'b0;
    endcase
  end

  assign w_to = w_other_req && (r_wdog == CNT_W'(TIMEOUT - 1));

  // Watchdog counter, cleared on every grant entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog   <= '0;
      r_to_evt <= 1'b0;
    end else begin
      r_to_evt <= w_to;
      if (w_grant_entry)    r_wdog <= '0;
      else if (w_other_req) r_wdog <= r_wdog + CNT_W'(1);
    end
  end

  assign timeout_evt = r_to_evt;
`else
  assign w_to        = 1'b0;
  assign timeout_evt = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: round-robin in IDLE, release only with chip select high
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        case (w_req_s)
          2'b01:   w_state_nxt = GRANT0;
          2'b10:   w_state_nxt = GRANT1;
          2'b11:   w_state_nxt = grant_state(~r_last);
          default: w_state_nxt = IDLE;
        endcase
      end
      GRANT0: begin
        if (w_to || (!w_req_s[REQ_JTAG] && w_csn_s[REQ_JTAG])) w_state_nxt = GAP;
      end
      GRANT1: begin
        if (w_to || (!w_req_s[REQ_USER] && w_csn_s[REQ_USER])) w_state_nxt = GAP;
      end
      GAP: begin
        if (r_gap == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_grant_entry = (r_state == IDLE) &&
                         ((w_state_nxt == GRANT0) || (w_state_nxt == GRANT1));

  // Round-robin history; a timeout leaves it pointing at the revoked owner,
  // which is already the value written on that owner's grant entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_last <= 1'b1;
    else if (w_grant_entry) r_last <= (w_state_nxt == GRANT1);
  end

  // Gap counter: loads on GAP entry, counts down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap <= '0;
    end else if ((w_state_nxt == GAP) && (r_state != GAP)) begin
      r_gap <= CNT_W'(CS_GAP - 1);
    end else if ((r_state == GAP) && (r_gap != '0)) begin
      r_gap <= r_gap - CNT_W'(1);
    end
  end

  // Grant and busy decoded from the next state so they are registered outputs
  always_comb begin
    w_gnt_nxt = 2'b00;
    case (w_state_nxt)
      GRANT0:  w_gnt_nxt = 2'b01;
      GRANT1:  w_gnt_nxt = 2'b10;
      default: w_gnt_nxt = 2'b00;
    endcase
  end

  // Registered grant and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt  <= 2'b00;
      r_busy <= 1'b0;
    end else begin
      r_gnt  <= w_gnt_nxt;
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  assign gnt  = r_gnt;
  assign busy = r_busy;

  // Combinational SPI mux; chip select forced high in the revocation cycle
  always_comb begin
    w_spi_csn = 1'b1;
    w_spi_clk = 1'b0;
    w_spi_si  = 1'b0;
    case (r_state)
      GRANT0: begin
        w_spi_csn = m_csn[REQ_JTAG] | w_to;
        w_spi_clk = m_clk[REQ_JTAG];
        w_spi_si  = m_si[REQ_JTAG];
      end
      GRANT1: begin
        w_spi_csn = m_csn[REQ_USER] | w_to;
        w_spi_clk = m_clk[REQ_USER];
        w_spi_si  = m_si[REQ_USER];
      end
      default: begin
        w_spi_csn = 1'b1;
        w_spi_clk = 1'b0;
        w_spi_si  = 1'b0;
      end
    endcase
  end

  assign spi_csn = w_spi_csn;
  assign spi_clk = w_spi_clk;
  assign spi_si  = w_spi_si;
  assign m_so    = spi_so;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter: directed bench for spi_flash_arbiter
// (CS_GAP=4, SYNC_STAGES=2, TIMEOUT=100). Honours SPI_ARB_TIMEOUT_EN.
module tb_spi_flash_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       busy;
  logic       timeout_evt;
  logic [1:0] m_csn;
  logic [1:0] m_clk;
  logic [1:0] m_si;
  logic       m_so;
  logic       spi_csn;
  logic       spi_clk;
  logic       spi_si;
  logic       spi_so;

  int n_checks = 0;
  int n_fail   = 0;

  spi_flash_arbiter #(
    .CS_GAP     (4),
    .SYNC_STAGES(2),
    .TIMEOUT    (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .gnt        (gnt),
    .busy       (busy),
    .timeout_evt(timeout_evt),
    .m_csn      (m_csn),
    .m_clk      (m_clk),
    .m_si       (m_si),
    .m_so       (m_so),
    .spi_csn    (spi_csn),
    .spi_clk    (spi_clk),
    .spi_si     (spi_si),
    .spi_so     (spi_so)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = 2'b00;
    m_csn  = 2'b11;
    m_clk  = 2'b00;
    m_si   = 2'b00;
    spi_so = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (timeout_evt !== 1'b0) begin n_fail++; $display("FAIL reset_tevt got=%b exp=0", timeout_evt); end
    n_checks++; if (spi_csn !== 1'b1) begin n_fail++; $display("FAIL reset_csn got=%b exp=1", spi_csn); end
    n_checks++; if (spi_clk !== 1'b0) begin n_fail++; $display("FAIL reset_clk got=%b exp=0", spi_clk); end
    n_checks++; if (spi_si !== 1'b0) begin n_fail++; $display("FAIL reset_si got=%b exp=0", spi_si); end
  endtask

  task automatic test_single_owner();
    logic [31:0] pat;
    do_reset();
    req = 2'b01;
    step(2);
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL so_early_gnt got=%b exp=00", gnt); end
    step(1);
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL so_grant_latency got=%b exp=01", gnt); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL so_busy got=%b exp=1", busy); end
    pat = 32'hA5C3_0F96;
    m_csn[0] = 1'b0;
    #1;
    n_checks++; if (spi_csn !== 1'b0) begin n_fail++; $display("FAIL so_csn_low got=%b exp=0", spi_csn); end
    for (int i = 31; i >= 0; i--) begin
      m_si[0]  = pat[i];
      m_clk[0] = 1'b0;
      m_csn[1] = pat[i];
      m_clk[1] = ~pat[i];
      m_si[1]  = ~pat[i];
      spi_so   = ~pat[i];
      #2;
      n_checks++; if (spi_csn !== 1'b0) begin n_fail++; $display("FAIL so_xfer_csn bit=%0d got=%b exp=0", i, spi_csn); end
      n_checks++; if (spi_si !== pat[i]) begin n_fail++; $display("FAIL so_xfer_si bit=%0d got=%b exp=%b", i, spi_si, pat[i]); end
      n_checks++; if (spi_clk !== 1'b0) begin n_fail++; $display("FAIL so_xfer_clk_lo bit=%0d got=%b exp=0", i, spi_clk); end
      n_checks++; if (m_so !== ~pat[i]) begin n_fail++; $display("FAIL so_m_so bit=%0d got=%b exp=%b", i, m_so, ~pat[i]); end
      m_clk[0] = 1'b1;
      #2;
      n_checks++; if (spi_clk !== 1'b1) begin n_fail++; $display("FAIL so_xfer_clk_hi bit=%0d got=%b exp=1", i, spi_clk); end
    end
    m_clk[0] = 1'b0;
    m_csn    = 2'b11;
    m_clk[1] = 1'b0;
    m_si     = 2'b00;
    #1;
    n_checks++; if (spi_csn !== 1'b1) begin n_fail++; $display("FAIL so_csn_end got=%b exp=1", spi_csn); end
    step(1);
    req = 2'b00;
    step(2);
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL so_rel_early got=%b exp=01", gnt); end
    step(1);
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL so_rel_latency got=%b exp=00", gnt); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL so_gap_busy got=%b exp=1", busy); end
    m_csn[0] = 1'b0;
    m_clk[0] = 1'b1;
    m_si[0]  = 1'b1;
    #1;
    n_checks++; if ({spi_csn, spi_clk, spi_si} !== 3'b100) begin n_fail++; $display("FAIL so_gap_pins got=%b exp=100", {spi_csn, spi_clk, spi_si}); end
    m_csn[0] = 1'b1;
    m_clk[0] = 1'b0;
    m_si[0]  = 1'b0;
    step(3);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL so_gap_len got=%b exp=1", busy); end
    step(1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL so_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_tie();
    do_reset();
    req = 2'b11;
    step(3);
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL tie_first got=%b exp=01", gnt); end
    req[0] = 1'b0;
    step(3);
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL tie_gap_gnt got=%b exp=00", gnt); end
    for (int c = 0; c < 4; c++) begin
      n_checks++; if ((spi_csn !== 1'b1) || (busy !== 1'b1)) begin n_fail++; $display("FAIL tie_gap cyc=%0d csn=%b busy=%b exp=1/1", c, spi_csn, busy); end
      if (c < 3) step(1);
    end
    step(1);
    n_checks++; if ((gnt !== 2'b00) || (busy !== 1'b0)) begin n_fail++; $display("FAIL tie_idle gnt=%b busy=%b exp=00/0", gnt, busy); end
    step(1);
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL tie_second got=%b exp=10", gnt); end
  endtask

  task automatic test_back_to_back();
    // From GRANT1: release and new request on the same cycle, re-request during GAP
    req = 2'b01;
    step(2);
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL b2b_hold got=%b exp=10", gnt); end
    step(1);
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL b2b_gap got=%b exp=00", gnt); end
    step(1);
    req = 2'b11;
    step(3);
    n_checks++; if ((gnt !== 2'b00) || (busy !== 1'b0)) begin n_fail++; $display("FAIL b2b_idle gnt=%b busy=%b exp=00/0", gnt, busy); end
    step(1);
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL b2b_rr got=%b exp=01", gnt); end
  endtask

  task automatic test_late_csn();
    do_reset();
    req = 2'b01;
    step(3);
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL late_grant got=%b exp=01", gnt); end
    m_csn[0] = 1'b0;
    step(1);
    req[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      n_checks++; if ((gnt !== 2'b01) || (spi_csn !== 1'b0)) begin n_fail++; $display("FAIL late_hold cyc=%0d gnt=%b csn=%b exp=01/0", c, gnt, spi_csn); end
    end
    m_csn[0] = 1'b1;
    #1;
    n_checks++; if (spi_csn !== 1'b1) begin n_fail++; $display("FAIL late_csn_rise got=%b exp=1", spi_csn); end
    step(2);
    n_checks++; if ((gnt !== 2'b01) || (spi_csn !== 1'b1)) begin n_fail++; $display("FAIL late_rel_early gnt=%b csn=%b exp=01/1", gnt, spi_csn); end
    step(1);
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL late_rel got=%b exp=00", gnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b10;
    step(3);
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rmid_grant got=%b exp=10", gnt); end
    m_csn[1] = 1'b0;
    #1;
    n_checks++; if (spi_csn !== 1'b0) begin n_fail++; $display("FAIL rmid_csn_low got=%b exp=0", spi_csn); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (spi_csn !== 1'b1) begin n_fail++; $display("FAIL rmid_csn got=%b exp=1", spi_csn); end
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rmid_gnt got=%b exp=00", gnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    m_csn[1] = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(2);
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rmid_regrant_early got=%b exp=00", gnt); end
    step(1);
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rmid_regrant got=%b exp=10", gnt); end
  endtask

  task automatic test_timeout();
    logic bad;
    do_reset();
    req = 2'b01;
    step(3);
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL to_grant got=%b exp=01", gnt); end
    m_csn[0] = 1'b0;
    req[1]   = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
    bad = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      step(1);
      if ((gnt !== 2'b01) || (spi_csn !== 1'b0) || (timeout_evt !== 1'b0)) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL to_hold_window got=1 exp=0"); end
    step(1);
    n_checks++; if ((gnt !== 2'b01) || (spi_csn !== 1'b1)) begin n_fail++; $display("FAIL to_revoke_cycle gnt=%b csn=%b exp=01/1", gnt, spi_csn); end
    step(1);
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL to_gnt got=%b exp=00", gnt); end
    n_checks++; if (timeout_evt !== 1'b1) begin n_fail++; $display("FAIL to_evt got=%b exp=1", timeout_evt); end
    n_checks++; if (spi_csn !== 1'b1) begin n_fail++; $display("FAIL to_gap_csn got=%b exp=1", spi_csn); end
    step(1);
    n_checks++; if (timeout_evt !== 1'b0) begin n_fail++; $display("FAIL to_evt_pulse got=%b exp=0", timeout_evt); end
    step(3);
    n_checks++; if ((gnt !== 2'b00) || (busy !== 1'b0)) begin n_fail++; $display("FAIL to_idle gnt=%b busy=%b exp=00/0", gnt, busy); end
    step(1);
    n_checks++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL to_next_owner got=%b exp=10", gnt); end
    n_checks++; if (spi_csn !== 1'b1) begin n_fail++; $display("FAIL to_next_csn got=%b exp=1", spi_csn); end
`else
    bad = 1'b0;
    for (int e = 1; e <= 10000; e++) begin
      step(1);
      if ((gnt !== 2'b01) || (timeout_evt !== 1'b0) || (spi_csn !== 1'b0)) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL noto_hold got=1 exp=0"); end
    n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL noto_gnt got=%b exp=01", gnt); end
`endif
    m_csn = 2'b11;
    req   = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog sim_time_exceeded got=timeout exp=finish");
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin
    rst_n  = 1'b0;
    req    = 2'b00;
    m_csn  = 2'b11;
    m_clk  = 2'b00;
    m_si   = 2'b00;
    spi_so = 1'b0;
    test_reset();
    test_single_owner();
    test_tie();
    test_back_to_back();
    test_late_csn();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
